// File: rtl/pc_seq_pkg.sv
// Shared definitions for the fetch sequencer: FSM encoding, parameter defaults
// and the redirect-target alignment helper.
package pc_seq_pkg;

  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_FETCH = 3'd1;
  localparam logic [2:0] S_DRAIN = 3'd2;
  localparam logic [2:0] S_STALL = 3'd3;
  localparam logic [2:0] S_HALT  = 3'd4;

  localparam logic [31:0] RESET_VECTOR_DEF = 32'h0000_0000;
  localparam int          PC_STEP_DEF      = 4;
  localparam int          ALIGN_BITS_DEF   = 2;

  function automatic logic [31:0] align_pc(input logic [31:0] addr, input int bits);
    logic [31:0] mask;
    mask = 32'hFFFF_FFFF << bits;
    return addr & mask;
  endfunction

endpackage

// File: rtl/pc_fetch_sequencer.sv
// Next-PC controller and req/ack instruction-fetch sequencer.
// PcNext is combinational from state; FetchAddr and FetchCount are registered.
module pc_fetch_sequencer
  import pc_seq_pkg::*;
#(
  parameter logic [31:0] RESET_VECTOR = RESET_VECTOR_DEF,
  parameter int          PC_STEP      = PC_STEP_DEF,
  parameter int          ALIGN_BITS   = ALIGN_BITS_DEF,
  parameter int          CNT_W        = 16
) (
  input  logic             Clk,
  input  logic             Reset,
  input  logic [31:0]      PcCur,
  output logic [31:0]      PcNext,
  output logic             FetchReq,
  output logic [31:0]      FetchAddr,
  input  logic             FetchAck,
  output logic             InstrValid,
  input  logic             Stall,
  input  logic             RedirectValid,
  input  logic [31:0]      RedirectTarget,
  input  logic             HaltReq,
  input  logic             Resume,
  output logic             Halted,
  output logic [CNT_W-1:0] FetchCount
);

  logic [2:0]       r_state;
  logic [31:0]      r_fetch_addr;
  logic [CNT_W-1:0] r_count;
  logic             r_halt_pend;

  logic [2:0]  w_state_nxt;
  logic [31:0] w_addr_nxt;
  logic [31:0] w_pc_next;
  logic        w_req;
  logic        w_valid;
  logic        w_halted;
  logic        w_halt_pend_nxt;
  logic [31:0] w_target;
  logic [31:0] w_step_pc;
  logic        w_halt;

  assign w_target  = align_pc(RedirectTarget, ALIGN_BITS);
  assign w_step_pc = PcCur + 32'(PC_STEP);
  assign w_halt    = HaltReq | r_halt_pend;

  always_comb begin
    w_state_nxt     = r_state;
    w_addr_nxt      = r_fetch_addr;
    w_pc_next       = PcCur;
    w_req           = 1'b0;
    w_valid         = 1'b0;
    w_halted        = 1'b0;
    w_halt_pend_nxt = r_halt_pend;
    case (r_state)
      S_IDLE: begin
        w_state_nxt = S_FETCH;
        w_addr_nxt  = PcCur;
      end
      S_FETCH: begin
        w_req = 1'b1;
        if (RedirectValid) begin
          // A redirect kills the in-flight instruction; without an ack we must
          // still drain the request before the new address can be issued.
          w_pc_next = w_target;
          if (HaltReq) w_halt_pend_nxt = 1'b1;
          if (FetchAck) w_addr_nxt = w_target;
          else          w_state_nxt = S_DRAIN;
        end else if (FetchAck) begin
          w_valid   = 1'b1;
          w_pc_next = w_step_pc;
          if (w_halt) begin
            w_state_nxt     = S_HALT;
            w_halt_pend_nxt = 1'b0;
          end else if (Stall) begin
            w_state_nxt = S_STALL;
          end else begin
            w_addr_nxt = w_step_pc;
          end
        end else if (HaltReq) begin
          w_halt_pend_nxt = 1'b1;
        end
      end
      S_DRAIN: begin
        w_req = 1'b1;
        if (RedirectValid) w_pc_next = w_target;
        if (HaltReq) w_halt_pend_nxt = 1'b1;
        if (FetchAck) begin
          w_state_nxt = S_FETCH;
          w_addr_nxt  = RedirectValid ? w_target : PcCur;
        end
      end
      S_STALL: begin
        if (RedirectValid) begin
          w_pc_next = w_target;
        end else if (HaltReq) begin
          w_state_nxt     = S_HALT;
          w_halt_pend_nxt = 1'b0;
        end else if (!Stall) begin
          w_state_nxt = S_FETCH;
          w_addr_nxt  = PcCur;
        end
      end
      S_HALT: begin
        w_halted = 1'b1;
        if (Resume && !HaltReq) begin
          w_state_nxt = S_FETCH;
          w_addr_nxt  = PcCur;
        end
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge Clk) begin
    if (Reset) begin
      r_state      <= S_IDLE;
      r_fetch_addr <= RESET_VECTOR;
      r_count      <= '0;
      r_halt_pend  <= 1'b0;
    end else begin
      r_state      <= w_state_nxt;
      r_fetch_addr <= w_addr_nxt;
      r_halt_pend  <= w_halt_pend_nxt;
      if (w_valid) r_count <= r_count + {{(CNT_W-1){1'b0}}, 1'b1};
    end
  end

  assign PcNext     = Reset ? RESET_VECTOR : w_pc_next;
  assign FetchReq   = w_req & ~Reset;
  assign InstrValid = w_valid & ~Reset;
  assign Halted     = w_halted & ~Reset;
  assign FetchAddr  = r_fetch_addr;
  assign FetchCount = r_count;

endmodule

// File: tb/tb_pc_fetch_sequencer.sv
// Directed bench for pc_fetch_sequencer with an external PC register model;
// FetchCount is narrowed to 4 bits so the counter wrap is reachable.
module tb_pc_fetch_sequencer;

  localparam int CW = 4;

  logic          clk = 1'b0;
  logic          reset;
  logic [31:0]   pc_cur;
  logic [31:0]   pc_next;
  logic          fetch_req;
  logic [31:0]   fetch_addr;
  logic          fetch_ack;
  logic          instr_valid;
  logic          stall;
  logic          redir_vld;
  logic [31:0]   redir_tgt;
  logic          halt_req;
  logic          resume;
  logic          halted;
  logic [CW-1:0] fetch_count;

  int n_chk  = 0;
  int n_fail = 0;

  pc_fetch_sequencer #(.CNT_W(CW)) dut (
    .Clk(clk), .Reset(reset), .PcCur(pc_cur), .PcNext(pc_next),
    .FetchReq(fetch_req), .FetchAddr(fetch_addr), .FetchAck(fetch_ack),
    .InstrValid(instr_valid), .Stall(stall), .RedirectValid(redir_vld),
    .RedirectTarget(redir_tgt), .HaltReq(halt_req), .Resume(resume),
    .Halted(halted), .FetchCount(fetch_count)
  );

  always #5 clk = ~clk;

  // The program counter the sequencer steers.
  always_ff @(posedge clk) pc_cur <= pc_next;

  typedef struct {
    logic        rst, ack, stl, rdv;
    logic [31:0] tgt;
    logic        hlt, res;
    logic        e_req;
    logic [31:0] e_addr;
    logic        e_vld;
    logic [31:0] e_pc;
    logic        e_hlt;
    logic [3:0]  e_cnt;
  } vec_t;

  vec_t vt[$];

  function automatic vec_t mk(logic rst, logic ack, logic stl, logic rdv, logic [31:0] tgt,
                              logic hlt, logic res, logic e_req, logic [31:0] e_addr,
                              logic e_vld, logic [31:0] e_pc, logic e_hlt, logic [3:0] e_cnt);
    vec_t v;
    v.rst = rst; v.ack = ack; v.stl = stl; v.rdv = rdv; v.tgt = tgt; v.hlt = hlt; v.res = res;
    v.e_req = e_req; v.e_addr = e_addr; v.e_vld = e_vld; v.e_pc = e_pc;
    v.e_hlt = e_hlt; v.e_cnt = e_cnt;
    return v;
  endfunction

  task automatic chk(input string name, input int idx, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s step %0d: got %h expected %h", name, idx, act, exp);
    end
  endtask

  task automatic drive(input logic rst, input logic ack, input logic stl, input logic rdv,
                       input logic [31:0] tgt, input logic hlt, input logic res);
    @(negedge clk);
    reset = rst; fetch_ack = ack; stall = stl; redir_vld = rdv;
    redir_tgt = tgt; halt_req = hlt; resume = res;
    #1;
  endtask

  task automatic check_all(input int idx, input logic e_req, input logic [31:0] e_addr,
                           input logic e_vld, input logic [31:0] e_pc, input logic e_hlt,
                           input logic [3:0] e_cnt);
    chk("FetchReq",   idx, {31'b0, fetch_req},   {31'b0, e_req});
    chk("FetchAddr",  idx, fetch_addr,           e_addr);
    chk("InstrValid", idx, {31'b0, instr_valid}, {31'b0, e_vld});
    chk("PcNext",     idx, pc_next,              e_pc);
    chk("Halted",     idx, {31'b0, halted},      {31'b0, e_hlt});
    chk("FetchCount", idx, {28'b0, fetch_count}, {28'b0, e_cnt});
  endtask

  initial begin
    //        rst ack stl rdv tgt           hlt res | req addr          vld pcnext        hlt cnt
    vt.push_back(mk(1,0,0,0,32'h0,        0,0, 0,32'h0,        0,32'h0,        0,4'd0));
    vt.push_back(mk(0,0,0,0,32'h0,        0,0, 0,32'h0,        0,32'h0,        0,4'd0));
    vt.push_back(mk(0,1,0,0,32'h0,        0,0, 1,32'h0,        1,32'h4,        0,4'd0));
    vt.push_back(mk(0,1,0,0,32'h0,        0,0, 1,32'h4,        1,32'h8,        0,4'd1));
    vt.push_back(mk(0,1,0,0,32'h0,        0,0, 1,32'h8,        1,32'hC,        0,4'd2));
    vt.push_back(mk(0,1,0,0,32'h0,        0,0, 1,32'hC,        1,32'h10,       0,4'd3));
    vt.push_back(mk(0,1,1,0,32'h0,        0,0, 1,32'h10,       1,32'h14,       0,4'd4));
    vt.push_back(mk(0,0,1,0,32'h0,        0,0, 0,32'h10,       0,32'h14,       0,4'd5));
    vt.push_back(mk(0,0,1,0,32'h0,        0,0, 0,32'h10,       0,32'h14,       0,4'd5));
    vt.push_back(mk(0,0,0,0,32'h0,        0,0, 0,32'h10,       0,32'h14,       0,4'd5));
    vt.push_back(mk(0,0,0,0,32'h0,        0,0, 1,32'h14,       0,32'h14,       0,4'd5));
    vt.push_back(mk(0,0,0,0,32'h0,        0,0, 1,32'h14,       0,32'h14,       0,4'd5));
    vt.push_back(mk(0,0,0,0,32'h0,        0,0, 1,32'h14,       0,32'h14,       0,4'd5));
    vt.push_back(mk(0,1,0,0,32'h0,        0,0, 1,32'h14,       1,32'h18,       0,4'd5));
    vt.push_back(mk(0,0,0,1,32'h103,      0,0, 1,32'h18,       0,32'h100,      0,4'd6));
    vt.push_back(mk(0,0,0,0,32'h0,        0,0, 1,32'h18,       0,32'h100,      0,4'd6));
    vt.push_back(mk(0,0,0,1,32'h202,      0,0, 1,32'h18,       0,32'h200,      0,4'd6));
    vt.push_back(mk(0,1,0,0,32'h0,        0,0, 1,32'h18,       0,32'h200,      0,4'd6));
    vt.push_back(mk(0,1,0,0,32'h0,        0,0, 1,32'h200,      1,32'h204,      0,4'd6));
    vt.push_back(mk(0,1,0,1,32'h40,       0,0, 1,32'h204,      0,32'h40,       0,4'd7));
    vt.push_back(mk(0,0,0,0,32'h0,        1,0, 1,32'h40,       0,32'h40,       0,4'd7));
    vt.push_back(mk(0,1,0,0,32'h0,        0,0, 1,32'h40,       1,32'h44,       0,4'd7));
    vt.push_back(mk(0,0,0,0,32'h0,        0,0, 0,32'h40,       0,32'h44,       1,4'd8));
    vt.push_back(mk(0,0,0,1,32'h80,       0,0, 0,32'h40,       0,32'h44,       1,4'd8));
    vt.push_back(mk(0,0,0,0,32'h0,        1,1, 0,32'h40,       0,32'h44,       1,4'd8));
    vt.push_back(mk(0,0,0,0,32'h0,        0,1, 0,32'h40,       0,32'h44,       1,4'd8));
    vt.push_back(mk(0,1,0,0,32'h0,        0,0, 1,32'h44,       1,32'h48,       0,4'd8));
    vt.push_back(mk(0,0,0,0,32'h0,        0,1, 1,32'h48,       0,32'h48,       0,4'd9));
    vt.push_back(mk(0,1,0,1,32'hFFFFFFFE, 0,0, 1,32'h48,       0,32'hFFFFFFFC, 0,4'd9));
    vt.push_back(mk(0,1,0,0,32'h0,        0,0, 1,32'hFFFFFFFC, 1,32'h0,        0,4'd9));
    for (int k = 0; k < 6; k++)
      vt.push_back(mk(0,1,0,0,32'h0, 0,0, 1,32'(4*k), 1,32'(4*k+4), 0,4'(10+k)));
    vt.push_back(mk(0,0,0,0,32'h0,        0,0, 1,32'h18,       0,32'h18,       0,4'd0));
    vt.push_back(mk(0,0,0,1,32'h300,      0,0, 1,32'h18,       0,32'h300,      0,4'd0));
    vt.push_back(mk(1,0,0,0,32'h0,        0,0, 0,32'h18,       0,32'h0,        0,4'd0));
    vt.push_back(mk(0,1,0,0,32'h0,        0,0, 0,32'h0,        0,32'h0,        0,4'd0));
    vt.push_back(mk(0,0,0,0,32'h0,        0,0, 1,32'h0,        0,32'h0,        0,4'd0));

    reset = 1'b1; fetch_ack = 1'b0; stall = 1'b0; redir_vld = 1'b0;
    redir_tgt = 32'h0; halt_req = 1'b0; resume = 1'b0;
    repeat (2) @(posedge clk);

    foreach (vt[i]) begin
      drive(vt[i].rst, vt[i].ack, vt[i].stl, vt[i].rdv, vt[i].tgt, vt[i].hlt, vt[i].res);
      check_all(i, vt[i].e_req, vt[i].e_addr, vt[i].e_vld, vt[i].e_pc, vt[i].e_hlt, vt[i].e_cnt);
    end

    // Slow memory straight out of reset: request and PC hold for three cycles.
    drive(1, 0, 0, 0, 32'h0, 0, 0);
    drive(1, 0, 0, 0, 32'h0, 0, 0);
    check_all(100, 0, 32'h0, 0, 32'h0, 0, 4'd0);
    drive(0, 0, 0, 0, 32'h0, 0, 0);
    for (int w = 0; w < 3; w++) begin
      drive(0, 0, 0, 0, 32'h0, 0, 0);
      check_all(101 + w, 1, 32'h0, 0, 32'h0, 0, 4'd0);
    end
    drive(0, 1, 0, 0, 32'h0, 0, 0);
    check_all(104, 1, 32'h0, 1, 32'h4, 0, 4'd0);
    drive(0, 0, 0, 0, 32'h0, 0, 0);
    check_all(105, 1, 32'h4, 0, 32'h4, 0, 4'd1);

    // Halt request while stalled takes priority over the stall release.
    drive(0, 1, 1, 0, 32'h0, 0, 0);
    check_all(106, 1, 32'h4, 1, 32'h8, 0, 4'd1);
    drive(0, 0, 0, 0, 32'h0, 1, 0);
    check_all(107, 0, 32'h4, 0, 32'h8, 0, 4'd2);
    drive(0, 0, 0, 0, 32'h0, 0, 0);
    check_all(108, 0, 32'h4, 0, 32'h8, 1, 4'd2);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
